bcd_display_scanner: RTL and testbench

Downstream consumer of the chained BCDcounter decade digits. It latches a multi-digit packed BCD value and drives a time-multiplexed common-anode-select 7-segment display, one digit per scan slot. It decodes each digit, optionally blanks leading zeros, and inserts an anti-ghosting guard interval at each slot start. All outputs are registered and active-HIGH.

---
 rtl/bcd_display_scanner.sv | 102 ++++++++++
 tb/tb_bcd_display_scanner.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// Multiplexed 7-segment scanner for a packed multi-digit BCD snapshot.
// Registered outputs, leading-zero blanking and a per-slot anti-ghost guard.
module bcd_display_scanner #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int GUARD    = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   BCD,
    input  logic                  LOAD,
    input  logic                  BLANK_LZ,
    output logic [6:0]            SEG,
    output logic [DIGITS-1:0]     AN,
    output logic                  FRAME
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);

    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRE_GUARD = PW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [4*DIGITS-1:0] snap;
    logic [PW-1:0]       pre;
    logic [IW-1:0]       idx;

    logic [3:0]          cur;
    logic [DIGITS-1:0]   blank;
    logic                allz;
    logic                lit;
    logic                slot_end;
    logic [DIGITS-1:0]   an_sel;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    // Walk from the most significant digit down; blanking stops at the
    // first non-zero code (invalid codes count as non-zero).
    always_comb begin
        blank = '0;
        allz  = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            allz     = allz & (snap[4*k +: 4] == 4'd0);
            blank[k] = BLANK_LZ & allz & (k != 0);
        end
    end

    always_comb begin
        cur      = snap[4*idx +: 4];
        lit      = (pre >= PRE_GUARD);
        slot_end = (pre == PRE_LAST);
        an_sel   = {{(DIGITS-1){1'b0}}, 1'b1} << idx;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            snap <= '0;
        end else if (LOAD) begin
            snap <= BCD;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre <= '0;
            idx <= '0;
        end else if (slot_end) begin
            pre <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            SEG   <= '0;
            AN    <= '0;
            FRAME <= 1'b0;
        end else begin
            AN    <= lit ? an_sel : '0;
            SEG   <= (lit && !blank[idx]) ? decode(cur) : 7'h00;
            FRAME <= slot_end && (idx == IDX_LAST);
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: directed scenarios plus randomized traffic
// checked against a cycle-count based behavioural model.
module tb_bcd_display_scanner;

    localparam int D = 4;
    localparam int P = 4;
    localparam int G = 1;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        LOAD = 1'b0;
    logic        BLANK_LZ = 1'b0;
    logic [15:0] BCD = 16'h0;
    logic [6:0]  SEG;
    logic [3:0]  AN;
    logic        FRAME;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    bcd_display_scanner #(
        .DIGITS(D),
        .PRESCALE(P),
        .GUARD(G)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .BCD(BCD),
        .LOAD(LOAD),
        .BLANK_LZ(BLANK_LZ),
        .SEG(SEG),
        .AN(AN),
        .FRAME(FRAME)
    );

    logic [6:0] segtab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
    };

    // Model: n counts non-reset edges since reset; slot position and digit
    // are plain arithmetic on n.
    int          n;
    logic [15:0] msnap;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_fr;

    function automatic int digit_of(logic [15:0] v, int k);
        return int'((v >> (4 * k)) & 16'hF);
    endfunction

    function automatic bit blanked(logic [15:0] v, int k, bit blz);
        return blz && (k > 0) && ((v >> (4 * k)) == 16'h0);
    endfunction

    function automatic logic [6:0] m_seg(int nn, logic [15:0] v, bit blz);
        if ((nn % P) < G) return 7'h00;
        if (blanked(v, (nn / P) % D, blz)) return 7'h00;
        return segtab[digit_of(v, (nn / P) % D)];
    endfunction

    function automatic logic [3:0] m_an(int nn);
        if ((nn % P) < G) return 4'h0;
        return 4'(1 << ((nn / P) % D));
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            n     <= 0;
            msnap <= 16'h0;
            e_seg <= 7'h00;
            e_an  <= 4'h0;
            e_fr  <= 1'b0;
        end else begin
            e_seg <= m_seg(n, msnap, BLANK_LZ);
            e_an  <= m_an(n);
            e_fr  <= ((n % P) == P - 1) && (((n / P) % D) == D - 1);
            n     <= n + 1;
            if (LOAD) msnap <= BCD;
        end
    end

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1; LOAD = 1'b1; BCD = 16'h1234; BLANK_LZ = 1'b1;
        repeat (2) @(negedge CLK);
        total++;
        if ({SEG, AN, FRAME} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs got seg=%h an=%b fr=%b want 0",
                     SEG, AN, FRAME);
        end
        RST = 1'b0; LOAD = 1'b0;
        @(negedge CLK);
        total++;
        if (AN !== 4'h0) begin
            bad++;
            $display("FAIL reset_guard got an=%b want 0000", AN);
        end
        @(negedge CLK);
        total++;
        if (AN !== 4'b0001 || SEG !== 7'h3F) begin
            bad++;
            $display("FAIL reset_first_digit got an=%b seg=%h want 0001 3f",
                     AN, SEG);
        end
    endtask

    task automatic test_scan();
        int last_fr = -1;
        int frames = 0;
        logic [3:0] last_lit = 4'h0;
        @(negedge CLK);
        LOAD = 1'b1; BCD = 16'h8888; BLANK_LZ = 1'b0;
        @(negedge CLK);
        LOAD = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            total++;
            if ({SEG, AN, FRAME} !== {e_seg, e_an, e_fr}) begin
                bad++;
                $display("FAIL scan_model got %h/%b/%b want %h/%b/%b",
                         SEG, AN, FRAME, e_seg, e_an, e_fr);
            end
            if (AN != 4'h0 && AN != last_lit) begin
                if (last_lit != 4'h0) begin
                    total++;
                    if (AN !== {last_lit[2:0], last_lit[3]}) begin
                        bad++;
                        $display("FAIL scan_order got an=%b after %b",
                                 AN, last_lit);
                    end
                end
                last_lit = AN;
            end
            if (FRAME === 1'b1) begin
                if (last_fr >= 0) begin
                    total++;
                    if (c - last_fr != 16) begin
                        bad++;
                        $display("FAIL frame_period got %0d want 16",
                                 c - last_fr);
                    end
                end
                last_fr = c;
                frames++;
            end
        end
        total++;
        if (frames < 2) begin
            bad++;
            $display("FAIL frame_count got %0d want >=2", frames);
        end
    endtask

    task automatic test_decode();
        int k;
        for (int v = 0; v < 16; v++) begin
            @(negedge CLK);
            LOAD = 1'b1; BCD = 16'(v); BLANK_LZ = 1'b0;
            @(negedge CLK);
            LOAD = 1'b0;
            @(negedge CLK);
            k = 0;
            while (AN !== 4'b0001 && k < 20) begin
                @(negedge CLK);
                k++;
            end
            total++;
            if (AN !== 4'b0001) begin
                bad++;
                $display("FAIL decode_timeout code=%0d an=%b", v, AN);
            end else if (SEG !== segtab[v]) begin
                bad++;
                $display("FAIL decode code=%0d got %h want %h",
                         v, SEG, segtab[v]);
            end
        end
    endtask

    task automatic test_blanking();
        logic [15:0] cb [4] = '{16'h0042, 16'h0000, 16'h0A00, 16'h0042};
        bit          cz [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [27:0] ce [4] = '{
            {7'h00, 7'h00, 7'h66, 7'h5B},
            {7'h00, 7'h00, 7'h00, 7'h3F},
            {7'h00, 7'h40, 7'h3F, 7'h3F},
            {7'h3F, 7'h3F, 7'h66, 7'h5B}
        };
        logic [27:0] e;
        logic [3:0]  seen;
        int          k;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            LOAD = 1'b1; BCD = cb[i]; BLANK_LZ = cz[i];
            @(negedge CLK);
            LOAD = 1'b0;
            @(negedge CLK);
            seen = 4'h0;
            e = ce[i];
            for (int c = 0; c < 20; c++) begin
                @(negedge CLK);
                if (AN != 4'h0) begin
                    k = 0;
                    for (int j = 0; j < 4; j++) if (AN[j]) k = j;
                    seen[k] = 1'b1;
                    total++;
                    if (SEG !== e[7*k +: 7]) begin
                        bad++;
                        $display("FAIL blank case=%0d digit=%0d got %h want %h",
                                 i, k, SEG, e[7*k +: 7]);
                    end
                end
            end
            total++;
            if (seen !== 4'hF) begin
                bad++;
                $display("FAIL blank_an case=%0d seen=%b want 1111", i, seen);
            end
        end
    endtask

    task automatic test_load_latency();
        logic [3:0] prev;
        int k = 0;
        @(negedge CLK);
        LOAD = 1'b1; BCD = 16'h0001; BLANK_LZ = 1'b0;
        @(negedge CLK);
        LOAD = 1'b0;
        prev = AN;
        @(negedge CLK);
        while (!(prev == 4'h0 && AN == 4'b0001) && k < 40) begin
            prev = AN;
            @(negedge CLK);
            k++;
        end
        LOAD = 1'b1; BCD = 16'h0007;
        @(negedge CLK);
        LOAD = 1'b0;
        total++;
        if (SEG !== 7'h06 || AN !== 4'b0001) begin
            bad++;
            $display("FAIL load_edge1 got %h/%b want 06/0001", SEG, AN);
        end
        @(negedge CLK);
        total++;
        if (SEG !== 7'h07 || AN !== 4'b0001) begin
            bad++;
            $display("FAIL load_edge2 got %h/%b want 07/0001", SEG, AN);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] prev;
        logic [3:0] first = 4'h0;
        int k = 0;
        int c = 0;
        prev = AN;
        @(negedge CLK);
        while (!(prev != 4'b0100 && AN == 4'b0100) && k < 40) begin
            prev = AN;
            @(negedge CLK);
            k++;
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        total++;
        if ({SEG, AN, FRAME} !== 12'h000) begin
            bad++;
            $display("FAIL midreset_outputs got %h/%b/%b want 0",
                     SEG, AN, FRAME);
        end
        while (c < 40) begin
            @(negedge CLK);
            c++;
            if (first == 4'h0 && AN != 4'h0) first = AN;
            if (FRAME === 1'b1) break;
        end
        total++;
        if (c != 16 || first !== 4'b0001) begin
            bad++;
            $display("FAIL midreset_restart got frame_at=%0d first=%b want 16 0001",
                     c, first);
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int c = 0; c < 600; c++) begin
            @(negedge CLK);
            total++;
            if ({SEG, AN, FRAME} !== {e_seg, e_an, e_fr}) begin
                bad++;
                $display("FAIL random_model c=%0d got %h/%b/%b want %h/%b/%b",
                         c, SEG, AN, FRAME, e_seg, e_an, e_fr);
            end
            if ($countones(AN) > 1) begin
                bad++;
                $display("FAIL random_onehot c=%0d an=%b", c, AN);
            end
            for (int j = 0; j < 4; j++)
                v[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0
                              : 4'($urandom_range(0, 15));
            BCD  = v;
            LOAD = ($urandom_range(0, 5) == 0);
            RST  = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) BLANK_LZ = ~BLANK_LZ;
        end
        @(negedge CLK);
        RST = 1'b0; LOAD = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_decode();
        test_blanking();
        test_load_latency();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
